vga_frame_reader: RTL and testbench
===================================

# vga_frame_reader

Source end of the display pixel path: generates 640x480@60 VGA timing and fetches 12-bit RGB444 pixels from the 160x120 camera frame buffer, upscaled 2x and tiled into all four screen quadrants. It drives the DE / x_pixel / y_pixel / RGB stream consumed by the image-filter stage, with timing and pixel data cycle-aligned despite frame-buffer read latency.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths
- V_VISIBLE, 480, active lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths
- IMG_WIDTH, 160, frame-buffer width in pixels
- IMG_HEIGHT, 120, frame-buffer height in lines
- RD_LATENCY, 1, frame-buffer read latency in clocks, legal range 1..3
- ADDR_WIDTH, 15, frame-buffer address width

Ports:
- clk  in  1  pixel clock (25 MHz). One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high
- fb_rd_en  out  1  frame-buffer read strobe
- fb_rd_addr  out  ADDR_WIDTH  frame-buffer read address
- fb_rd_data  in  12  {R,G,B} returned RD_LATENCY clocks after address
- h_sync  out  1  active-low horizontal sync
- v_sync  out  1  active-low vertical sync
- DE  out  1  active-video enable
- x_pixel  out  10  output column, 0..799
- y_pixel  out  10  output line, 0..524
- r_out / g_out / b_out  out  4 each  pixel colour
- vblank_start  out  1  one-clock pulse at first blanking line, for frame-buffer swap

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (800), increments every clock, wraps to 0; v_cnt 0..V_TOTAL-1 (525), increments when h_cnt wraps, wraps to 0 after 524.
- Active region: h_cnt < 640 and v_cnt < 480.
- Quadrant mapping: lx = (h_cnt mod 320) >> 1, ly = (v_cnt mod 240) >> 1. Address = ly*160 + lx, computed exactly, range 0..19199. Implementation is free (shift-add or incremental), provided the result matches.
- fb_rd_en = 1 only for active-region counter values. In blanking, fb_rd_en = 0 and the address holds its last value.
- Sync: h_sync = 0 for h_cnt 656..751; v_sync = 0 for v_cnt 490..491; otherwise 1.
- Output colour = fb_rd_data when the aligned DE = 1, else 0.
- vblank_start = 1 for the single output cycle whose aligned coordinates are (0,480).
- Reset (async, any time including mid-line or mid-frame):
  - Counters go to (0,0).
  - The delay line clears.
  - Outputs go to h_sync=1, v_sync=1, DE=0, x_pixel=0, y_pixel=0, RGB=0, fb_rd_en=0, fb_rd_addr=0, vblank_start=0.
  - After release, the counter is (0,0) on the first clock edge.

## Timing
- Cycle t: counter = (h,v).
- Cycle t+1: fb_rd_en / fb_rd_addr for (h,v), registered.
- Cycle t+1+RD_LATENCY: fb_rd_data for (h,v) valid.
- Cycle t+2+RD_LATENCY: registered outputs h_sync, v_sync, DE, x_pixel=h, y_pixel=v, RGB, vblank_start all reflect (h,v).
- Pipeline latency P = RD_LATENCY+2. All outputs shift together, so no skew exists between timing and colour.
- For the first P clocks after reset, outputs hold reset values.
- Line period is 800 clocks; frame period is 420000 clocks.
- Counter wraps at (799,524)->(0,0) with no idle cycle. Pipelined outputs wrap identically.

## Test plan
- Reset mid-frame: assert reset at counter (400,300) for 3 clocks, release. Required:
  - all outputs at reset values immediately;
  - after release, first valid output x_pixel=0, y_pixel=0, DE=1 exactly P clocks later.
- Line and frame timing over 2 frames:
  - h_sync low for exactly 96 clocks per 800, starting at x_pixel=656;
  - v_sync low for exactly 1600 clocks per 420000;
  - DE high for exactly 307200 clocks per frame.
- Address mapping:
  - counter (0,0) -> 0; (3,0) -> 1; (0,2) -> 160; (320,0) -> 0; (321,241) -> 0;
  - (639,479) -> 19199; (319,239) -> 19199.
  - fb_rd_en=0 at (640,0) and (0,480).
- Alignment with RD_LATENCY=1 and 3: memory model returns data = address[11:0] after RD_LATENCY clocks. Required:
  - {r_out,g_out,b_out} equals the expected address for the emitted (x_pixel,y_pixel) on every active pixel;
  - RGB=0 whenever DE=0.
- vblank_start: exactly one pulse per frame, coincident with x_pixel=0, y_pixel=480, DE=0.

Source files
------------

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing generator that fetches RGB444 pixels from a 160x120 frame buffer,
// upscaled 2x and tiled into four quadrants, with timing delayed to match the read latency.
module vga_frame_reader #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120,
   parameter int RD_LATENCY = 1,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  fb_rd_en,
   output logic [ADDR_WIDTH-1:0] fb_rd_addr,
   input  logic [11:0]           fb_rd_data,
   output logic                  h_sync,
   output logic                  v_sync,
   output logic                  DE,
   output logic [9:0]            x_pixel,
   output logic [9:0]            y_pixel,
   output logic [3:0]            r_out,
   output logic [3:0]            g_out,
   output logic [3:0]            b_out,
   output logic                  vblank_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   // One quadrant spans twice the image in each direction because of the 2x upscale.
   localparam logic [9:0] H_TILE = 10'(2 * IMG_WIDTH);
   localparam logic [9:0] V_TILE = 10'(2 * IMG_HEIGHT);

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       vb;
      logic [9:0] x;
      logic [9:0] y;
   } timing_t;

   localparam timing_t TIMING_RST = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};

   logic [9:0]            h_cnt_r;
   logic [9:0]            v_cnt_r;
   logic                  h_wrap_s;
   logic                  active_s;
   logic [9:0]            h_mod_s;
   logic [9:0]            v_mod_s;
   logic [ADDR_WIDTH-1:0] addr_s;
   timing_t               stage_s;
   timing_t               pipe_r [0:RD_LATENCY];
   timing_t               aligned_s;

   // Raster counters: horizontal every clock, vertical on horizontal wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_r <= 10'd0;
         v_cnt_r <= 10'd0;
      end else if (h_wrap_s) begin
         h_cnt_r <= 10'd0;
         if (v_cnt_r == V_LAST) begin
            v_cnt_r <= 10'd0;
         end else begin
            v_cnt_r <= v_cnt_r + 10'd1;
         end
      end else begin
         h_cnt_r <= h_cnt_r + 10'd1;
      end
   end

   // Decode the current counter into timing flags and the quadrant-folded read address.
   always_comb begin
      h_wrap_s = (h_cnt_r == H_LAST);
      active_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
      // Active area is two tiles wide and tall, so a single conditional subtract is a full modulo there.
      if (h_cnt_r >= H_TILE) begin
         h_mod_s = h_cnt_r - H_TILE;
      end else begin
         h_mod_s = h_cnt_r;
      end
      if (v_cnt_r >= V_TILE) begin
         v_mod_s = v_cnt_r - V_TILE;
      end else begin
         v_mod_s = v_cnt_r;
      end
      addr_s = ADDR_WIDTH'(v_mod_s >> 1) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(h_mod_s >> 1);
      stage_s.hs = !((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
      stage_s.vs = !((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
      stage_s.de = active_s;
      stage_s.vb = (h_cnt_r == 10'd0) && (v_cnt_r == V_VIS);
      stage_s.x  = h_cnt_r;
      stage_s.y  = v_cnt_r;
   end

   // Frame-buffer read request; the address holds through blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_rd_en   <= 1'b0;
         fb_rd_addr <= '0;
      end else begin
         fb_rd_en <= active_s;
         if (active_s) begin
            fb_rd_addr <= addr_s;
         end else begin
            fb_rd_addr <= fb_rd_addr;
         end
      end
   end

   // Timing delay line: stage 0 is level with the read request, the last stage with read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= RD_LATENCY; i++) begin
            pipe_r[i] <= TIMING_RST;
         end
      end else begin
         pipe_r[0] <= stage_s;
         for (int i = 1; i <= RD_LATENCY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign aligned_s = pipe_r[RD_LATENCY];

   // Output register: timing and colour leave together; colour is blanked outside active video.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_sync       <= 1'b1;
         v_sync       <= 1'b1;
         DE           <= 1'b0;
         x_pixel      <= 10'd0;
         y_pixel      <= 10'd0;
         vblank_start <= 1'b0;
         r_out        <= 4'd0;
         g_out        <= 4'd0;
         b_out        <= 4'd0;
      end else begin
         h_sync       <= aligned_s.hs;
         v_sync       <= aligned_s.vs;
         DE           <= aligned_s.de;
         x_pixel      <= aligned_s.x;
         y_pixel      <= aligned_s.y;
         vblank_start <= aligned_s.vb;
         if (aligned_s.de) begin
            {r_out, g_out, b_out} <= fb_rd_data;
         end else begin
            {r_out, g_out, b_out} <= 12'd0;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: full-size instance (latency 1) and a short-frame
// instance (latency 3, 8 visible lines, 4-line tiles) for whole-frame timing.
module tb_vga_frame_reader;

   localparam int P_A = 3;
   localparam int P_B = 5;
   localparam int FRAME_B = 15 * 800;
   localparam logic [35:0] RST_OBS = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0, 1'b0};

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc;
   int   tests = 0;
   int   fails = 0;

   logic        fb_rd_en_a, h_sync_a, v_sync_a, de_a, vb_a;
   logic [14:0] fb_rd_addr_a;
   logic [11:0] fb_rd_data_a;
   logic [9:0]  x_a, y_a;
   logic [3:0]  r_a, g_a, b_a;
   logic        fb_rd_en_b, h_sync_b, v_sync_b, de_b, vb_b;
   logic [14:0] fb_rd_addr_b;
   logic [11:0] fb_rd_data_b;
   logic [9:0]  x_b, y_b;
   logic [3:0]  r_b, g_b, b_b;
   logic [35:0] obs_a, obs_b;
   logic [11:0] mem_a_r;
   logic [11:0] mem_b_r [0:2];

   always #5 clk = ~clk;

   vga_frame_reader dut_a (
      .clk(clk), .reset(reset), .fb_rd_en(fb_rd_en_a), .fb_rd_addr(fb_rd_addr_a),
      .fb_rd_data(fb_rd_data_a), .h_sync(h_sync_a), .v_sync(v_sync_a), .DE(de_a),
      .x_pixel(x_a), .y_pixel(y_a), .r_out(r_a), .g_out(g_a), .b_out(b_a),
      .vblank_start(vb_a)
   );

   vga_frame_reader #(
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .IMG_HEIGHT(2), .RD_LATENCY(3)
   ) dut_b (
      .clk(clk), .reset(reset), .fb_rd_en(fb_rd_en_b), .fb_rd_addr(fb_rd_addr_b),
      .fb_rd_data(fb_rd_data_b), .h_sync(h_sync_b), .v_sync(v_sync_b), .DE(de_b),
      .x_pixel(x_b), .y_pixel(y_b), .r_out(r_b), .g_out(g_b), .b_out(b_b),
      .vblank_start(vb_b)
   );

   assign obs_a = {h_sync_a, v_sync_a, de_a, x_a, y_a, r_a, g_a, b_a, vb_a};
   assign obs_b = {h_sync_b, v_sync_b, de_b, x_b, y_b, r_b, g_b, b_b, vb_b};

   // Memory models return address[11:0] one and three clocks after the address.
   always @(posedge clk) begin
      mem_a_r    <= fb_rd_addr_a[11:0];
      mem_b_r[0] <= fb_rd_addr_b[11:0];
      mem_b_r[1] <= mem_b_r[0];
      mem_b_r[2] <= mem_b_r[1];
   end
   assign fb_rd_data_a = mem_a_r;
   assign fb_rd_data_b = mem_b_r[2];

   // Clock edges since the last reset release.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Expected output bundle after cy edges, for pipeline depth p.
   function automatic logic [35:0] model(input int cy, input int p, input int vt, input int vv,
                                         input int vs0, input int iw, input int ih);
      int c, x, y, a;
      logic hs, vs, de, vb;
      logic [11:0] rgb;
      if (cy < p) return RST_OBS;
      c  = cy - p;
      x  = c % 800;
      y  = (c / 800) % vt;
      de = (x < 640) && (y < vv);
      hs = !((x >= 656) && (x < 752));
      vs = !((y >= vs0) && (y < vs0 + 2));
      vb = (x == 0) && (y == vv);
      a  = ((y % (2 * ih)) / 2) * iw + (x % (2 * iw)) / 2;
      rgb = de ? a[11:0] : 12'd0;
      return {hs, vs, de, x[9:0], y[9:0], rgb, vb};
   endfunction

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 50000) begin
         @(negedge clk);
         guard++;
      end
      tests++;
      if (cyc !== target) begin
         $display("FAIL wait_cyc reached %0d required %0d", cyc, target);
         fails++;
      end
   endtask

   task automatic test_reset;
      #12;
      tests++;
      if ({obs_a, fb_rd_en_a, fb_rd_addr_a} !== {RST_OBS, 16'd0}) begin
         $display("FAIL por_state_a got %h want %h", {obs_a, fb_rd_en_a, fb_rd_addr_a}, {RST_OBS, 16'd0});
         fails++;
      end
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(P_A - 1);
      tests++;
      if (obs_a !== RST_OBS) begin
         $display("FAIL hold_before_p_a got %h want %h", obs_a, RST_OBS); fails++;
      end
      wait_cyc(P_A);
      tests++;
      if ({x_a, y_a, de_a} !== {10'd0, 10'd0, 1'b1}) begin
         $display("FAIL first_pixel_a got %h want %h", {x_a, y_a, de_a}, {10'd0, 10'd0, 1'b1}); fails++;
      end
      wait_cyc(P_B - 1);
      tests++;
      if (obs_b !== RST_OBS) begin
         $display("FAIL hold_before_p_b got %h want %h", obs_b, RST_OBS); fails++;
      end
      wait_cyc(P_B);
      tests++;
      if ({x_b, y_b, de_b} !== {10'd0, 10'd0, 1'b1}) begin
         $display("FAIL first_pixel_b got %h want %h", {x_b, y_b, de_b}, {10'd0, 10'd0, 1'b1}); fails++;
      end
      // Counter sits at (400,2); outputs show (397,2) on A and (395,2) on B.
      wait_cyc(2000);
      tests++;
      if ({x_a, y_a, de_a, r_a, g_a, b_a} !== {10'd397, 10'd2, 1'b1, 12'h0C6}) begin
         $display("FAIL midline_a got %h want %h", {x_a, y_a, de_a, r_a, g_a, b_a}, {10'd397, 10'd2, 1'b1, 12'h0C6}); fails++;
      end
      tests++;
      if ({x_b, y_b, de_b, r_b, g_b, b_b} !== {10'd395, 10'd2, 1'b1, 12'h0C5}) begin
         $display("FAIL midline_b got %h want %h", {x_b, y_b, de_b, r_b, g_b, b_b}, {10'd395, 10'd2, 1'b1, 12'h0C5}); fails++;
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({obs_a, fb_rd_en_a, fb_rd_addr_a} !== {RST_OBS, 16'd0}) begin
         $display("FAIL async_reset_a got %h want %h", {obs_a, fb_rd_en_a, fb_rd_addr_a}, {RST_OBS, 16'd0}); fails++;
      end
      tests++;
      if ({obs_b, fb_rd_en_b, fb_rd_addr_b} !== {RST_OBS, 16'd0}) begin
         $display("FAIL async_reset_b got %h want %h", {obs_b, fb_rd_en_b, fb_rd_addr_b}, {RST_OBS, 16'd0}); fails++;
      end
      repeat (3) @(negedge clk);
      tests++;
      if ({obs_a, fb_rd_en_a, fb_rd_addr_a} !== {RST_OBS, 16'd0}) begin
         $display("FAIL reset_held_a got %h want %h", {obs_a, fb_rd_en_a, fb_rd_addr_a}, {RST_OBS, 16'd0}); fails++;
      end
      reset = 1'b0;
      wait_cyc(P_A - 1);
      tests++;
      if (obs_a !== RST_OBS) begin
         $display("FAIL rerelease_hold_a got %h want %h", obs_a, RST_OBS); fails++;
      end
      wait_cyc(P_A);
      tests++;
      if ({x_a, y_a, de_a} !== {10'd0, 10'd0, 1'b1}) begin
         $display("FAIL rerelease_first_a got %h want %h", {x_a, y_a, de_a}, {10'd0, 10'd0, 1'b1}); fails++;
      end
      wait_cyc(P_B);
      tests++;
      if ({x_b, y_b, de_b} !== {10'd0, 10'd0, 1'b1}) begin
         $display("FAIL rerelease_first_b got %h want %h", {x_b, y_b, de_b}, {10'd0, 10'd0, 1'b1}); fails++;
      end
   endtask

   task automatic test_addr_map;
      // Counter linear index (v*800+h) and required {fb_rd_en, fb_rd_addr}.
      int          a_lin [12] = '{0, 3, 319, 320, 321, 639, 640, 799, 800, 1600, 1601, 2239};
      logic [15:0] a_exp [12] = '{{1'b1, 15'd0}, {1'b1, 15'd1}, {1'b1, 15'd159}, {1'b1, 15'd0},
                                  {1'b1, 15'd0}, {1'b1, 15'd159}, {1'b0, 15'd159}, {1'b0, 15'd159},
                                  {1'b1, 15'd0}, {1'b1, 15'd160}, {1'b1, 15'd160}, {1'b1, 15'd319}};
      int          b_lin [5]  = '{2719, 3200, 4321, 6239, 6400};
      logic [15:0] b_exp [5]  = '{{1'b1, 15'd319}, {1'b1, 15'd0}, {1'b1, 15'd0},
                                  {1'b1, 15'd319}, {1'b0, 15'd319}};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         wait_cyc(a_lin[i] + 1);
         tests++;
         if ({fb_rd_en_a, fb_rd_addr_a} !== a_exp[i]) begin
            $display("FAIL addr_a[%0d] lin=%0d got %h want %h", i, a_lin[i], {fb_rd_en_a, fb_rd_addr_a}, a_exp[i]);
            fails++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         wait_cyc(b_lin[i] + 1);
         tests++;
         if ({fb_rd_en_b, fb_rd_addr_b} !== b_exp[i]) begin
            $display("FAIL addr_b[%0d] lin=%0d got %h want %h", i, b_lin[i], {fb_rd_en_b, fb_rd_addr_b}, b_exp[i]);
            fails++;
         end
      end
   endtask

   task automatic test_align_a;
      int bad, blank_nz, de_cnt;
      logic [35:0] e;
      bad = 0; blank_nz = 0; de_cnt = 0;
      do_reset();
      for (int k = 1; k <= 2600; k++) begin
         @(negedge clk);
         e = model(cyc, P_A, 525, 480, 490, 160, 120);
         if (obs_a !== e) bad++;
         if (!de_a && {r_a, g_a, b_a} !== 12'd0) blank_nz++;
         if (de_a) de_cnt++;
      end
      tests++;
      if (bad !== 0) begin $display("FAIL align_a mismatches got %0d want 0", bad); fails++; end
      tests++;
      if (blank_nz !== 0) begin $display("FAIL blank_rgb_a got %0d want 0", blank_nz); fails++; end
      tests++;
      if (de_cnt !== 2118) begin $display("FAIL de_count_a got %0d want 2118", de_cnt); fails++; end
   endtask

   task automatic test_frame_b;
      int bad, hs_low, vs_low, de_cnt, falls, fall_bad, vbn, vb_bad;
      logic prev_hs;
      logic [35:0] e;
      bad = 0; hs_low = 0; vs_low = 0; de_cnt = 0; falls = 0; fall_bad = 0; vbn = 0; vb_bad = 0;
      prev_hs = 1'b1;
      do_reset();
      for (int k = 1; k < P_B + 2 * FRAME_B; k++) begin
         @(negedge clk);
         e = model(cyc, P_B, 15, 8, 10, 160, 2);
         if (obs_b !== e) bad++;
         if (cyc >= P_B) begin
            if (!h_sync_b) hs_low++;
            if (!v_sync_b) vs_low++;
            if (de_b) de_cnt++;
            if (prev_hs && !h_sync_b) begin
               falls++;
               if (x_b !== 10'd656) fall_bad++;
            end
            if (vb_b) begin
               vbn++;
               if ({x_b, y_b, de_b} !== {10'd0, 10'd8, 1'b0}) vb_bad++;
            end
         end
         prev_hs = h_sync_b;
      end
      tests++;
      if (bad !== 0) begin $display("FAIL align_b mismatches got %0d want 0", bad); fails++; end
      tests++;
      if (hs_low !== 2880) begin $display("FAIL hsync_low got %0d want 2880", hs_low); fails++; end
      tests++;
      if ({falls, fall_bad} !== {32'd30, 32'd0}) begin
         $display("FAIL hsync_start got falls=%0d bad=%0d want 30/0", falls, fall_bad); fails++;
      end
      tests++;
      if (vs_low !== 3200) begin $display("FAIL vsync_low got %0d want 3200", vs_low); fails++; end
      tests++;
      if (de_cnt !== 10240) begin $display("FAIL de_count_b got %0d want 10240", de_cnt); fails++; end
      tests++;
      if ({vbn, vb_bad} !== {32'd2, 32'd0}) begin
         $display("FAIL vblank got pulses=%0d bad=%0d want 2/0", vbn, vb_bad); fails++;
      end
   endtask

   initial begin
      test_reset();
      test_addr_map();
      test_align_a();
      test_frame_b();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
